// File: rtl/fm_tune_ctrl_if.sv
// Configuration handshake between spi_config and fm_tune_ctrl:
// the target carrier increment and DAC mask, qualified by valid/ready.
interface fm_tune_ctrl_if #(
  parameter int N = 18,
  parameter int D = 4
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_acc_inc;
  logic [D-1:0] cfg_dac_ena;

  modport master (
    output cfg_valid,
    output cfg_acc_inc,
    output cfg_dac_ena,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_acc_inc,
    input  cfg_dac_ena,
    output cfg_ready
  );
endinterface

// File: rtl/fm_tune_ctrl.sv
// fm_tune_ctrl: click-free power sequencing and glide retuning of the FM modulator
// carrier increment and DAC mask. Define FM_TUNE_DONE_IRQ_EN to add the done_irq pulse.
module fm_tune_ctrl #(
  parameter int N         = 18,
  parameter int D         = 4,
  parameter int STEP      = 64,
  parameter int TICK_DIV  = 1024,
  parameter int MUTE_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_en,
  fm_tune_ctrl_if.slave cfg,
  output logic [N-1:0]  acc_inc,
  output logic [D-1:0]  dac_ena,
  output logic          audio_mute,
  output logic          busy
`ifdef FM_TUNE_DONE_IRQ_EN
  ,
  output logic          done_irq
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(MUTE_HOLD + 1);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(MUTE_HOLD);
  localparam logic [N-1:0]  STEP_N    = N'(STEP);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_PUP    = 3'd1;
  localparam logic [2:0] S_ON     = 3'd2;
  localparam logic [2:0] S_RETUNE = 3'd3;
  localparam logic [2:0] S_PDN    = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [PW-1:0] presc_reg;
  logic          tick;
  logic [N-1:0]  tgt_acc_reg;
  logic [D-1:0]  tgt_dac_reg;
  logic [N-1:0]  acc_reg, acc_next;
  logic [D-1:0]  dac_reg, dac_next;
  logic          mute_reg, mute_next;
  logic          busy_reg, busy_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          cfg_ready_w;
  logic          cfg_accept;

  assign tick        = (presc_reg == TICK_LAST);
  assign cfg_ready_w = (state_reg == S_OFF) || (state_reg == S_ON);
  assign cfg_accept  = cfg.cfg_valid && cfg_ready_w;
  assign cfg.cfg_ready = cfg_ready_w;

  // Power-up enables the lowest still-missing target bit; power-down drops the highest live bit.
  logic [D-1:0] up_cand, up_bit, dn_bit;
  logic         hi_found;

  assign up_cand = tgt_dac_reg & ~dac_reg;
  assign up_bit  = up_cand & (~up_cand + D'(1));

  always_comb begin
    dn_bit   = '0;
    hi_found = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      if (dac_reg[i] && !hi_found) begin
        dn_bit[i] = 1'b1;
        hi_found  = 1'b1;
      end
    end
  end

  // Glide step toward target, clamped so it never overshoots or wraps.
  logic         up_dir;
  logic [N-1:0] diff, glide_acc;

  assign up_dir    = (tgt_acc_reg > acc_reg);
  assign diff      = up_dir ? (tgt_acc_reg - acc_reg) : (acc_reg - tgt_acc_reg);
  assign glide_acc = (diff > STEP_N) ? (up_dir ? (acc_reg + STEP_N) : (acc_reg - STEP_N))
                                     : tgt_acc_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    dac_next   = dac_reg;
    mute_next  = mute_reg;
    hold_next  = hold_reg;
    case (state_reg)
      S_OFF: begin
        if (tx_en) begin
          acc_next   = cfg_accept ? cfg.cfg_acc_inc : tgt_acc_reg;
          state_next = S_PUP;
        end
      end
      S_PUP: begin
        if (!tx_en) begin
          state_next = S_PDN;
        end else if (dac_reg == tgt_dac_reg) begin
          state_next = S_ON;
          mute_next  = 1'b0;
        end else if (tick) begin
          dac_next = dac_reg | up_bit;
        end
      end
      S_ON: begin
        if (!tx_en) begin
          state_next = S_PDN;
          mute_next  = 1'b1;
        end else if (tgt_acc_reg != acc_reg) begin
          state_next = S_RETUNE;
          mute_next  = 1'b1;
        end else if ((tgt_dac_reg != dac_reg) && tick) begin
          dac_next = tgt_dac_reg;
        end
      end
      S_RETUNE: begin
        if (!tx_en) begin
          state_next = S_PDN;
        end else if (acc_reg != tgt_acc_reg) begin
          if (tick) begin
            acc_next = glide_acc;
            if (glide_acc == tgt_acc_reg) begin
              hold_next = HOLD_INIT;
            end
          end
        end else if (hold_reg == '0) begin
          state_next = S_ON;
          mute_next  = 1'b0;
          dac_next   = tgt_dac_reg;
        end else if (tick) begin
          hold_next = hold_reg - HW'(1);
        end
      end
      S_PDN: begin
        mute_next = 1'b1;
        if (dac_reg == '0) begin
          state_next = S_OFF;
        end else if (tick) begin
          dac_next = dac_reg & ~dn_bit;
        end
      end
      default: begin
        state_next = S_OFF;
        mute_next  = 1'b1;
      end
    endcase
  end

  assign busy_next = (state_next == S_PUP) || (state_next == S_RETUNE) || (state_next == S_PDN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_OFF;
      presc_reg   <= '0;
      tgt_acc_reg <= '0;
      tgt_dac_reg <= '0;
      acc_reg     <= '0;
      dac_reg     <= '0;
      mute_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      hold_reg    <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= tick ? '0 : (presc_reg + PW'(1));
      if (cfg_accept) begin
        tgt_acc_reg <= cfg.cfg_acc_inc;
        tgt_dac_reg <= cfg.cfg_dac_ena;
      end
      acc_reg  <= acc_next;
      dac_reg  <= dac_next;
      mute_reg <= mute_next;
      busy_reg <= busy_next;
      hold_reg <= hold_next;
    end
  end

  assign acc_inc    = acc_reg;
  assign dac_ena    = dac_reg;
  assign audio_mute = mute_reg;
  assign busy       = busy_reg;

`ifdef FM_TUNE_DONE_IRQ_EN
  // Reset-forced OFF never pulses: the register is held at 0 by reset itself.
  logic done_irq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_irq_reg <= 1'b0;
    end else begin
      done_irq_reg <= (state_next != state_reg) &&
                      ((state_next == S_ON) || (state_next == S_OFF));
    end
  end

  assign done_irq = done_irq_reg;
`endif

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Scoreboard bench for fm_tune_ctrl: every change of (acc_inc, dac_ena, audio_mute, busy)
// is matched in order against the expected output sequence queued by each scenario task.
`timescale 1ns/1ps
module tb_fm_tune_ctrl;
  localparam int N = 18;
  localparam int D = 4;
  localparam int STEP = 64;
  localparam int TICK_DIV = 4;
  localparam int MUTE_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         tx_en = 1'b0;
  logic [N-1:0] acc_inc;
  logic [D-1:0] dac_ena;
  logic         audio_mute;
  logic         busy;
`ifdef FM_TUNE_DONE_IRQ_EN
  logic         done_irq;
  int           irq_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [N-1:0] acc;
    logic [D-1:0] dac;
    logic         mute;
    logic         busy;
  } obs_t;

  obs_t exp_q[$];
  obs_t prev_obs;
  obs_t cur_obs;
  obs_t exp_obs;
  bit   mon_en = 1'b0;

  fm_tune_ctrl_if #(.N(N), .D(D)) cfg_bus ();

  fm_tune_ctrl #(
    .N(N), .D(D), .STEP(STEP), .TICK_DIV(TICK_DIV), .MUTE_HOLD(MUTE_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_en(tx_en),
    .cfg(cfg_bus),
    .acc_inc(acc_inc),
    .dac_ena(dac_ena),
    .audio_mute(audio_mute),
    .busy(busy)
`ifdef FM_TUNE_DONE_IRQ_EN
    ,
    .done_irq(done_irq)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: each observed output change pops and compares the next expected tuple.
  always @(negedge clk) begin
    if (mon_en) begin
      cur_obs.acc  = acc_inc;
      cur_obs.dac  = dac_ena;
      cur_obs.mute = audio_mute;
      cur_obs.busy = busy;
      if (cur_obs !== prev_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got acc=%0d dac=%b mute=%b busy=%b, required no change",
                   cur_obs.acc, cur_obs.dac, cur_obs.mute, cur_obs.busy);
        end else begin
          exp_obs = exp_q.pop_front();
          if (cur_obs !== exp_obs) begin
            errors++;
            $display("FAIL sb_output: got acc=%0d dac=%b mute=%b busy=%b, required acc=%0d dac=%b mute=%b busy=%b",
                     cur_obs.acc, cur_obs.dac, cur_obs.mute, cur_obs.busy,
                     exp_obs.acc, exp_obs.dac, exp_obs.mute, exp_obs.busy);
          end else begin
            $display("ok: acc=%0d dac=%b mute=%b busy=%b", cur_obs.acc, cur_obs.dac, cur_obs.mute, cur_obs.busy);
          end
        end
        prev_obs = cur_obs;
      end
    end
  end

`ifdef FM_TUNE_DONE_IRQ_EN
  always @(negedge clk) begin
    if (done_irq === 1'b1) irq_cnt++;
  end
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [N-1:0] a, input logic [D-1:0] d, input logic m, input logic b);
    obs_t o;
    o.acc = a; o.dac = d; o.mute = m; o.busy = b;
    exp_q.push_back(o);
  endtask

  // Reference glide: mute/busy raise, clamped steps of STEP, then return to ON.
  task automatic glide_expect(input int from, input int to, input logic [D-1:0] d);
    int cur;
    cur = from;
    push(cur[N-1:0], d, 1'b1, 1'b1);
    while (cur != to) begin
      if (to > cur) cur = (to - cur > STEP) ? cur + STEP : to;
      else          cur = (cur - to > STEP) ? cur - STEP : to;
      push(cur[N-1:0], d, 1'b1, 1'b1);
    end
    push(to[N-1:0], d, 1'b0, 1'b0);
  endtask

  task automatic send_cfg(input logic [N-1:0] a, input logic [D-1:0] d);
    cfg_bus.cfg_valid   = 1'b1;
    cfg_bus.cfg_acc_inc = a;
    cfg_bus.cfg_dac_ena = d;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected outputs pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    cfg_bus.cfg_valid   = 1'b0;
    cfg_bus.cfg_acc_inc = '0;
    cfg_bus.cfg_dac_ena = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (acc_inc !== 18'd0) begin errors++; $display("FAIL reset_acc: got %0d required 0", acc_inc); end
    checks++; if (dac_ena !== 4'b0000) begin errors++; $display("FAIL reset_dac: got %b required 0000", dac_ena); end
    checks++; if (audio_mute !== 1'b1) begin errors++; $display("FAIL reset_mute: got %b required 1", audio_mute); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cfg_bus.cfg_ready); end
    rst_n = 1'b1;
    prev_obs = '{acc: '0, dac: '0, mute: 1'b1, busy: 1'b0};
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_power_up();
`ifdef FM_TUNE_DONE_IRQ_EN
    int irq0;
    irq0 = irq_cnt;
`endif
    send_cfg(18'd1000, 4'b1111);
    push(18'd1000, 4'b0000, 1'b1, 1'b1);
    push(18'd1000, 4'b0001, 1'b1, 1'b1);
    push(18'd1000, 4'b0011, 1'b1, 1'b1);
    push(18'd1000, 4'b0111, 1'b1, 1'b1);
    push(18'd1000, 4'b1111, 1'b1, 1'b1);
    push(18'd1000, 4'b1111, 1'b0, 1'b0);
    tx_en = 1'b1;
    @(negedge clk);
    checks++; if (acc_inc !== 18'd1000) begin errors++; $display("FAIL pup_acc_load: got %0d required 1000", acc_inc); end
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL pup_ready: got %b required 0", cfg_bus.cfg_ready); end
    wait_sb_empty(100, "power_up");
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL on_ready: got %b required 1", cfg_bus.cfg_ready); end
`ifdef FM_TUNE_DONE_IRQ_EN
    checks++; if (irq_cnt - irq0 !== 1) begin errors++; $display("FAIL irq_on_entry: got %0d pulses required 1", irq_cnt - irq0); end
`endif
  endtask

  task automatic test_retune_up();
    int n;
    push(18'd1000, 4'b1111, 1'b1, 1'b1);
    push(18'd1064, 4'b1111, 1'b1, 1'b1);
    push(18'd1128, 4'b1111, 1'b1, 1'b1);
    push(18'd1192, 4'b1111, 1'b1, 1'b1);
    push(18'd1200, 4'b1111, 1'b1, 1'b1);
    push(18'd1200, 4'b1111, 1'b0, 1'b0);
    send_cfg(18'd1200, 4'b1111);
    n = 0;
    while (acc_inc !== 18'd1200 && n < 100) begin @(negedge clk); n++; end
    checks++; if (acc_inc !== 18'd1200) begin errors++; $display("FAIL glide_reach: got %0d required 1200", acc_inc); end
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL retune_ready: got %b required 0", cfg_bus.cfg_ready); end
    checks++; if (audio_mute !== 1'b1) begin errors++; $display("FAIL retune_mute: got %b required 1", audio_mute); end
    n = 0;
    while (audio_mute !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checks++; if (n !== 9) begin errors++; $display("FAIL mute_hold_cycles: got %0d required 9", n); end
    wait_sb_empty(20, "retune_up");
  endtask

  task automatic test_retune_down();
    glide_expect(1200, 1150, 4'b1111);
    send_cfg(18'd1150, 4'b1111);
    wait_sb_empty(60, "retune_down_small");
    checks++; if (acc_inc !== 18'd1150) begin errors++; $display("FAIL down_small: got %0d required 1150", acc_inc); end
    glide_expect(1150, 1000, 4'b1111);
    send_cfg(18'd1000, 4'b1111);
    wait_sb_empty(80, "retune_down");
    checks++; if (acc_inc !== 18'd1000) begin errors++; $display("FAIL down_land: got %0d required 1000", acc_inc); end
  endtask

  task automatic test_power_down();
    int n;
`ifdef FM_TUNE_DONE_IRQ_EN
    int irq0;
    irq0 = irq_cnt;
`endif
    push(18'd1000, 4'b1111, 1'b1, 1'b1);
    push(18'd1064, 4'b1111, 1'b1, 1'b1);
    push(18'd1128, 4'b1111, 1'b1, 1'b1);
    push(18'd1128, 4'b0111, 1'b1, 1'b1);
    push(18'd1128, 4'b0011, 1'b1, 1'b1);
    push(18'd1128, 4'b0001, 1'b1, 1'b1);
    push(18'd1128, 4'b0000, 1'b1, 1'b1);
    push(18'd1128, 4'b0000, 1'b1, 1'b0);
    send_cfg(18'd1200, 4'b1111);
    n = 0;
    while (acc_inc !== 18'd1128 && n < 100) begin @(negedge clk); n++; end
    checks++; if (acc_inc !== 18'd1128) begin errors++; $display("FAIL pdn_reach: got %0d required 1128", acc_inc); end
    tx_en = 1'b0;
    n = 0;
    while (dac_ena !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    wait_sb_empty(100, "power_down");
    checks++; if (acc_inc !== 18'd1128) begin errors++; $display("FAIL acc_frozen: got %0d required 1128", acc_inc); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL off_ready: got %b required 1", cfg_bus.cfg_ready); end
`ifdef FM_TUNE_DONE_IRQ_EN
    checks++; if (irq_cnt - irq0 !== 1) begin errors++; $display("FAIL irq_off_entry: got %0d pulses required 1", irq_cnt - irq0); end
`endif
  endtask

  task automatic test_zero_target();
    send_cfg(18'd1000, 4'b1111);
    push(18'd1000, 4'b0000, 1'b1, 1'b1);
    push(18'd1000, 4'b0001, 1'b1, 1'b1);
    push(18'd1000, 4'b0011, 1'b1, 1'b1);
    push(18'd1000, 4'b0111, 1'b1, 1'b1);
    push(18'd1000, 4'b1111, 1'b1, 1'b1);
    push(18'd1000, 4'b1111, 1'b0, 1'b0);
    tx_en = 1'b1;
    wait_sb_empty(100, "repower");
    glide_expect(1000, 0, 4'b1111);
    send_cfg(18'd0, 4'b1111);
    wait_sb_empty(200, "glide_to_zero");
    checks++; if (acc_inc !== 18'd0) begin errors++; $display("FAIL zero_landing: got %0d required 0", acc_inc); end
    push(18'd0, 4'b0011, 1'b0, 1'b0);
    send_cfg(18'd0, 4'b0011);
    wait_sb_empty(20, "mask_change");
    push(18'd0, 4'b0011, 1'b1, 1'b1);
    push(18'd0, 4'b0001, 1'b1, 1'b1);
    push(18'd0, 4'b0000, 1'b1, 1'b1);
    push(18'd0, 4'b0000, 1'b1, 1'b0);
    tx_en = 1'b0;
    wait_sb_empty(50, "mask_power_down");
  endtask

  task automatic test_zero_mask_reset();
    int n;
`ifdef FM_TUNE_DONE_IRQ_EN
    int irq0;
`endif
    push(18'd500, 4'b0000, 1'b1, 1'b1);
    push(18'd500, 4'b0000, 1'b0, 1'b0);
    send_cfg(18'd500, 4'b0000);
    tx_en = 1'b1;
    n = 0;
    while (audio_mute !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 2) begin errors++; $display("FAIL zero_mask_on_cycles: got %0d required 2", n); end
    push(18'd500, 4'b0000, 1'b1, 1'b1);
    push(18'd500, 4'b0000, 1'b1, 1'b0);
    tx_en = 1'b0;
    wait_sb_empty(20, "zero_mask_off");
    push(18'd700, 4'b0000, 1'b1, 1'b1);
    push(18'd700, 4'b0001, 1'b1, 1'b1);
    push(18'd700, 4'b0011, 1'b1, 1'b1);
    send_cfg(18'd700, 4'b1111);
    tx_en = 1'b1;
    wait_sb_empty(50, "pup_before_reset");
`ifdef FM_TUNE_DONE_IRQ_EN
    irq0 = irq_cnt;
`endif
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (acc_inc !== 18'd0) begin errors++; $display("FAIL async_rst_acc: got %0d required 0", acc_inc); end
    checks++; if (dac_ena !== 4'b0000) begin errors++; $display("FAIL async_rst_dac: got %b required 0000", dac_ena); end
    checks++; if (audio_mute !== 1'b1) begin errors++; $display("FAIL async_rst_mute: got %b required 1", audio_mute); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b required 0", busy); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b required 1", cfg_bus.cfg_ready); end
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_obs = '{acc: '0, dac: '0, mute: 1'b1, busy: 1'b0};
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0 || dac_ena !== 4'b0000) begin errors++; $display("FAIL stay_off: got busy=%b dac=%b required busy=0 dac=0000", busy, dac_ena); end
`ifdef FM_TUNE_DONE_IRQ_EN
    checks++; if (irq_cnt !== irq0) begin errors++; $display("FAIL irq_on_reset: got %0d pulses required 0", irq_cnt - irq0); end
`endif
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_retune_up();
    test_retune_down();
    test_power_down();
    test_zero_target();
    test_zero_mask_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fm_tune_ctrl.md
Name: fm_tune_ctrl

Overview:
Sequencing controller for the FM modulator datapath. It owns the carrier increment (acc_inc) and DAC bit-enable mask (dac_ena) fed to fm_modulator. It provides click-free power-up and power-down by enabling or disabling DAC bits one per tick. It retunes without spectral splatter by gliding acc_inc toward a new target in bounded steps while muting audio. Inputs come from spi_config targets and a transmit-enable; outputs drive fm_modulator and the audio path.

Parameters:
N, 18, phase accumulator / acc_inc width
D, 4, DAC width / dac_ena mask width
STEP, 64, max |change| of acc_inc per tick during retune
TICK_DIV, 1024, clk cycles per sequencing tick (>=2)
MUTE_HOLD, 16, ticks audio stays muted after glide completes (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_en  in  1  transmit enable (level)
cfg_valid  in  1  new target present
cfg_ready  out  1  target accepted when cfg_valid & cfg_ready
cfg_acc_inc  in  N  target carrier increment
cfg_dac_ena  in  D  target DAC bit mask
acc_inc  out  N  carrier increment to modulator (registered)
dac_ena  out  D  DAC bit mask to modulator (registered)
audio_mute  out  1  1 = modulator audio forced to zero
busy  out  1  1 in POWER_UP, RETUNE, POWER_DOWN

Behaviour:
- Reset (async, rst_n=0): state=OFF; acc_inc=0; dac_ena=0; audio_mute=1; busy=0; cfg_ready=1; tgt_acc=0; tgt_dac=0; prescaler=0; hold counter=0.
- Prescaler: free-running 0..TICK_DIV-1. tick=1 for one clk when count==TICK_DIV-1. All "per tick" actions occur on that edge.
- Config capture: cfg_ready=1 in OFF and ON only. On cfg_valid&cfg_ready, tgt_acc/tgt_dac are loaded at that edge; outputs are unchanged that cycle.
- OFF:
  - tx_en=1 -> acc_inc<=tgt_acc at once, since RF is off; go POWER_UP.
  - A config accepted in the same cycle as tx_en=1 is used for that load.
- POWER_UP:
  - Per tick, set the lowest bit of (tgt_dac & ~dac_ena).
  - When dac_ena==tgt_dac (checked every cycle, including tgt_dac=0 on entry) -> ON with audio_mute<=0.
  - tx_en=0 -> POWER_DOWN.
- ON: priority order tx_en=0 > acc change > mask change.
  - tx_en=0 -> POWER_DOWN with audio_mute<=1. A config accepted in that cycle is stored but not applied.
  - Else if tgt_acc!=acc_inc -> RETUNE with audio_mute<=1.
  - Else if tgt_dac!=dac_ena -> dac_ena<=tgt_dac at next tick.
- RETUNE:
  - Per tick, acc_inc moves toward tgt_acc by min(STEP, |diff|), using unsigned compare; no wrap, result is always between old value and target.
  - On reaching equality, the hold counter loads MUTE_HOLD and decrements per tick. At 0 -> ON with audio_mute<=0, and dac_ena<=tgt_dac if it differs.
  - tx_en=0 at any point -> POWER_DOWN with acc_inc frozen.
- POWER_DOWN:
  - audio_mute=1.
  - Per tick, clear the highest set bit of dac_ena. When dac_ena==0 -> OFF.
  - tx_en re-asserting is ignored until OFF is reached; OFF then restarts POWER_UP on the next cycle.
- busy is registered with the state: 1 exactly in POWER_UP, RETUNE, POWER_DOWN.
- Reset mid-operation returns everything to the reset values immediately; no ramp-down.

Optional Feature:
FM_TUNE_DONE_IRQ_EN:
- Defined: adds output done_irq (1 bit, reset 0), a one-clk pulse on every entry to ON or OFF, excluding the reset-forced OFF.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. TICK_DIV=4, cfg acc=1000 dac=4'b1111 in OFF, then tx_en=1:
   - acc_inc=1000 the next cycle.
   - dac_ena steps 0001, 0011, 0111, 1111 on ticks 1..4.
   - ON with audio_mute=0; busy high throughout the ramp.
2. In ON at acc=1000, cfg acc=1200, STEP=64, MUTE_HOLD=2:
   - acc_inc 1064, 1128, 1192, 1200 on successive ticks.
   - audio_mute stays 1 for 2 more ticks, then 0.
   - cfg_ready=0 during RETUNE.
3. Downward retune 1200 -> 1150: acc_inc=1150 after 1 tick with no underflow; then 1000 -> 0 lands exactly on 0.
4. tx_en=0 mid-RETUNE at acc_inc=1128:
   - acc_inc stays 1128.
   - dac_ena steps 0111, 0011, 0001, 0000 on ticks 1..4; state OFF, busy=0.
   - tx_en pulsed high during the ramp has no effect.
5. cfg dac=0 then tx_en=1: ON within 2 cycles with dac_ena=0. Assert rst_n=0 mid POWER_UP: all outputs return to reset values asynchronously.
6. With FM_TUNE_DONE_IRQ_EN: done_irq pulses exactly once on each ON and OFF entry in scenarios 1 and 4, and never on reset.
